// File: rtl/y_operand_stage.sv
// Operand-A receiver: captures the (optionally extended) bus value into a
// two-entry buffer and hands the head entry to the ALU with valid/ready.
module y_operand_stage #(
  parameter int                 WIDTH     = 16,
  parameter logic [WIDTH-1:0]   CONST_VAL = 16'h0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] from_bus,
  input  logic             Y_in,
  input  logic [1:0]       ext_mode,
  input  logic             flush,
  input  logic             alu_ready,
  output logic [WIDTH-1:0] to_ALU,
  output logic             alu_valid,
  output logic             full,
  output logic             overflow_err,
  output logic [WIDTH-1:0] REG_OUT_Y1,
  output logic [WIDTH-1:0] REG_OUT_Y2
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] y1_r, y1_nxt_s;
  logic [WIDTH-1:0] y2_r, y2_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic             valid_r, full_r;
  logic [WIDTH-1:0] cap_val_s;
  logic             cap_s, pop_s;

  // Byte-extension and constant injection applied on the way into the buffer.
  function automatic logic [WIDTH-1:0] transform(input logic [1:0] mode,
                                                 input logic [WIDTH-1:0] bus);
    logic [WIDTH-1:0] res;
    case (mode)
      2'b00:   res = bus;
      2'b01:   res = {{(WIDTH-8){1'b0}}, bus[7:0]};
      2'b10:   res = {{(WIDTH-8){bus[7]}}, bus[7:0]};
      2'b11:   res = CONST_VAL;
      default: res = bus;
    endcase
    return res;
  endfunction

  assign cap_val_s = transform(ext_mode, from_bus);
  assign cap_s     = Y_in;
  assign pop_s     = valid_r & alu_ready;

  // Next-state and buffer data movement; flush overrides capture and pop.
  always_comb begin
    state_nxt_s = state_r;
    y1_nxt_s    = y1_r;
    y2_nxt_s    = y2_r;
    ovf_nxt_s   = ovf_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (cap_s) begin
            y1_nxt_s    = cap_val_s;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (cap_s && pop_s) begin
            y1_nxt_s = cap_val_s;
          end else if (cap_s) begin
            y2_nxt_s    = cap_val_s;
            state_nxt_s = ST_TWO;
          end else if (pop_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s && cap_s) begin
            y1_nxt_s = y2_r;
            y2_nxt_s = cap_val_s;
          end else if (pop_s) begin
            y1_nxt_s    = y2_r;
            state_nxt_s = ST_ONE;
          end else if (cap_s) begin
            ovf_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State, buffer and status flags; status is registered from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_EMPTY;
      y1_r    <= {WIDTH{1'b0}};
      y2_r    <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      y1_r    <= y1_nxt_s;
      y2_r    <= y2_nxt_s;
      ovf_r   <= ovf_nxt_s;
      valid_r <= (state_nxt_s != ST_EMPTY);
      full_r  <= (state_nxt_s == ST_TWO);
    end
  end

  assign to_ALU       = y1_r;
  assign alu_valid    = valid_r;
  assign full         = full_r;
  assign overflow_err = ovf_r;
  assign REG_OUT_Y1   = y1_r;
  assign REG_OUT_Y2   = y2_r;

endmodule

// File: tb/tb_y_operand_stage.sv
// Directed bench for y_operand_stage: consumed operands are checked by a
// scoreboard monitor; flags and debug views are checked inline.
module tb_y_operand_stage;

  logic        clk;
  logic        reset;
  logic [15:0] from_bus;
  logic        Y_in;
  logic [1:0]  ext_mode;
  logic        flush;
  logic        alu_ready;
  logic [15:0] to_ALU;
  logic        alu_valid;
  logic        full;
  logic        overflow_err;
  logic [15:0] REG_OUT_Y1;
  logic [15:0] REG_OUT_Y2;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];

  y_operand_stage dut (
    .clk          (clk),
    .reset        (reset),
    .from_bus     (from_bus),
    .Y_in         (Y_in),
    .ext_mode     (ext_mode),
    .flush        (flush),
    .alu_ready    (alu_ready),
    .to_ALU       (to_ALU),
    .alu_valid    (alu_valid),
    .full         (full),
    .overflow_err (overflow_err),
    .REG_OUT_Y1   (REG_OUT_Y1),
    .REG_OUT_Y2   (REG_OUT_Y2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: whenever the ALU takes the head, it must match the oldest expected operand.
  always @(negedge clk) begin
    if (reset && alu_valid && alu_ready && !flush) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %h expected none", to_ALU);
      end else begin
        chk("operand", to_ALU, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic cap, input logic [1:0] mode, input logic [15:0] bus,
                       input logic rdy, input logic fl, input logic push,
                       input logic [15:0] e);
    Y_in      = cap;
    ext_mode  = mode;
    from_bus  = bus;
    alu_ready = rdy;
    flush     = fl;
    if (fl) exp_q.delete();
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    Y_in      = 1'b0;
    alu_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic pop1();
    drive(1'b0, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    reset = 1'b0; from_bus = 16'h0000; Y_in = 1'b0; ext_mode = 2'b00;
    flush = 1'b0; alu_ready = 1'b0;
    #1;
    chk("rst_valid", {15'd0, alu_valid}, 16'd0);
    chk("rst_full", {15'd0, full}, 16'd0);
    chk("rst_ovf", {15'd0, overflow_err}, 16'd0);
    chk("rst_to_alu", to_ALU, 16'h0000);
    chk("rst_y2", REG_OUT_Y2, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // pop while empty is ignored
    pop1();
    chk("empty_pop_valid", {15'd0, alu_valid}, 16'd0);

    // single capture latency
    drive(1'b1, 2'b00, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    chk("t1_to_alu", to_ALU, 16'hBEEF);
    chk("t1_valid", {15'd0, alu_valid}, 16'd1);
    chk("t1_full", {15'd0, full}, 16'd0);
    pop1();
    chk("t1_drained", {15'd0, alu_valid}, 16'd0);

    // fill two entries, sign-extend second
    drive(1'b1, 2'b00, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234);
    drive(1'b1, 2'b10, 16'h00F0, 1'b0, 1'b0, 1'b1, 16'hFFF0);
    chk("t2_full", {15'd0, full}, 16'd1);
    chk("t2_y1", REG_OUT_Y1, 16'h1234);
    chk("t2_y2", REG_OUT_Y2, 16'hFFF0);
    pop1();
    chk("t2_pop_to_alu", to_ALU, 16'hFFF0);
    chk("t2_pop_full", {15'd0, full}, 16'd0);

    // overflow: third capture while full is dropped
    drive(1'b1, 2'b00, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h1111);
    drive(1'b1, 2'b00, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("t3_ovf", {15'd0, overflow_err}, 16'd1);
    chk("t3_y1", REG_OUT_Y1, 16'hFFF0);
    chk("t3_y2", REG_OUT_Y2, 16'h1111);
    chk("t3_full", {15'd0, full}, 16'd1);
    pop1();
    pop1();
    chk("t3_empty", {15'd0, alu_valid}, 16'd0);
    chk("t3_ovf_sticky", {15'd0, overflow_err}, 16'd1);

    // capture with simultaneous pop in ONE, const and zero-extend modes
    drive(1'b1, 2'b00, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0005);
    drive(1'b1, 2'b11, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h0001);
    chk("t4_const", to_ALU, 16'h0001);
    chk("t4_full", {15'd0, full}, 16'd0);
    chk("t4_valid", {15'd0, alu_valid}, 16'd1);
    drive(1'b1, 2'b01, 16'hAB80, 1'b1, 1'b0, 1'b1, 16'h0080);
    chk("t4_zext", to_ALU, 16'h0080);
    pop1();

    // TWO with pop and cap, then flush beats cap and pop
    drive(1'b1, 2'b00, 16'hAAAA, 1'b0, 1'b0, 1'b1, 16'hAAAA);
    drive(1'b1, 2'b00, 16'hBBBB, 1'b0, 1'b0, 1'b1, 16'hBBBB);
    drive(1'b1, 2'b00, 16'hCCCC, 1'b1, 1'b0, 1'b1, 16'hCCCC);
    chk("t5_shift_y1", REG_OUT_Y1, 16'hBBBB);
    chk("t5_shift_y2", REG_OUT_Y2, 16'hCCCC);
    chk("t5_shift_full", {15'd0, full}, 16'd1);
    drive(1'b1, 2'b00, 16'hDDDD, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("t5_flush_valid", {15'd0, alu_valid}, 16'd0);
    chk("t5_flush_full", {15'd0, full}, 16'd0);
    chk("t5_flush_ovf", {15'd0, overflow_err}, 16'd1);
    chk("t5_flush_y1_kept", REG_OUT_Y1, 16'hBBBB);
    drive(1'b1, 2'b00, 16'h0E0E, 1'b0, 1'b0, 1'b1, 16'h0E0E);
    chk("t5_after_flush", to_ALU, 16'h0E0E);
    pop1();

    // asynchronous reset mid-cycle while TWO
    drive(1'b1, 2'b00, 16'h1357, 1'b0, 1'b0, 1'b1, 16'h1357);
    drive(1'b1, 2'b00, 16'h2468, 1'b0, 1'b0, 1'b1, 16'h2468);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_valid", {15'd0, alu_valid}, 16'd0);
    chk("t6_full", {15'd0, full}, 16'd0);
    chk("t6_to_alu", to_ALU, 16'h0000);
    chk("t6_ovf", {15'd0, overflow_err}, 16'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_stays_empty", {15'd0, alu_valid}, 16'd0);

    chk("queue_drained", exp_q.size() == 0 ? 16'd0 : 16'd1, 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y_operand_stage.md
Name: y_operand_stage

Overview:
- Bus-side receiver for ALU operand A; the counterpart of the Z stage, which drives ALU results onto the shared bus.
- Captures the 16-bit value on the single internal bus when Y_in is asserted, optionally transforms it, and holds it in a 2-entry buffer (Y1 head, Y2 tail).
- Presents the head to the ALU with a valid/ready handshake, so a bus transfer can land while the ALU is still consuming the previous operand.

Parameters:
- WIDTH, 16, datapath width of the bus and operand.
- CONST_VAL, 16'h0001, constant injected when ext_mode = 2'b11 (PC increment).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- from_bus  input  WIDTH  shared internal bus value.
- Y_in  input  1  capture strobe: latch the transformed from_bus this edge.
- ext_mode  input  2  transform applied at capture: 00 pass, 01 zero-extend [7:0], 10 sign-extend [7:0], 11 CONST_VAL.
- flush  input  1  synchronous clear of both entries.
- alu_ready  input  1  ALU consumes the head this edge when alu_valid = 1.
- to_ALU  output  WIDTH  head entry (Y1), operand A.
- alu_valid  output  1  head entry holds data.
- full  output  1  both entries occupied.
- overflow_err  output  1  sticky: a capture was dropped because the buffer was full.
- REG_OUT_Y1  output  WIDTH  debug view of Y1.
- REG_OUT_Y2  output  WIDTH  debug view of Y2.

Behaviour:
- Reset asserted (reset = 0), asynchronous:
  - Y1 = Y2 = 0, state EMPTY.
  - alu_valid = 0, full = 0, overflow_err = 0, to_ALU = 0.
- State encoding: EMPTY (0 entries), ONE (Y1 valid), TWO (Y1 and Y2 valid).
- alu_valid = (state != EMPTY). full = (state == TWO).
- to_ALU = Y1 combinationally. Y1 holds its last value when EMPTY and is never tri-stated.
- Transform, computed combinationally from from_bus at the capture edge:
  - 01: {8'h00, from_bus[7:0]}.
  - 10: {{8{from_bus[7]}}, from_bus[7:0]}.
  - 11: CONST_VAL; from_bus is ignored.
- Definitions used below: cap = Y_in; pop = alu_valid & alu_ready.
- Transitions and data movement:
  - EMPTY, cap: Y1 <= t, go to ONE. A pop in EMPTY is ignored.
  - ONE, cap & !pop: Y2 <= t, go to TWO.
  - ONE, cap & pop: Y1 <= t, stay in ONE.
  - ONE, !cap & pop: go to EMPTY.
  - TWO, pop & !cap: Y1 <= Y2, go to ONE.
  - TWO, pop & cap: Y1 <= Y2, Y2 <= t, stay in TWO.
  - TWO, cap & !pop: capture dropped, overflow_err <= 1, Y1/Y2 unchanged.
- Latency: a value captured at edge N into an empty stage appears on to_ALU with alu_valid = 1 after edge N (visible in cycle N+1).
- Pass-through: no same-cycle bypass from from_bus to to_ALU.
- flush has priority over cap and pop:
  - state <= EMPTY; Y1/Y2 keep their values; overflow_err unchanged.
  - Y_in in the same cycle is discarded.
- overflow_err clears only on reset.
- Y2 contents are don't-care outside TWO, but are still driven on REG_OUT_Y2.
- Reset asserted mid-transfer: all state clears immediately, no pending capture survives.
- Reset deassertion is used synchronously by the system; no capture occurs on the deassertion edge unless Y_in is high.

Test Plan:
- Reset, then Y_in = 1, ext_mode = 00, from_bus = 16'hBEEF, alu_ready = 0 -> next cycle to_ALU = 16'hBEEF, alu_valid = 1, full = 0.
- Capture 16'h1234 (ext 00), then 16'h00F0 (ext 10), alu_ready = 0 -> full = 1, REG_OUT_Y1 = 16'h1234, REG_OUT_Y2 = 16'hFFF0. Then pop one -> to_ALU = 16'hFFF0, full = 0.
- When TWO, a third Y_in with alu_ready = 0 -> overflow_err = 1 and stays 1. Y1/Y2 unchanged. Two pops drain to EMPTY, and overflow_err is still 1.
- When ONE holding 16'h0005: Y_in with ext 11 and alu_ready = 1 in the same cycle -> state ONE, to_ALU = 16'h0001. Then ext 01 with from_bus = 16'hAB80 -> 16'h0080.
- When TWO: assert flush together with Y_in and alu_ready -> alu_valid = 0, full = 0 next cycle, overflow_err unchanged.
- When TWO: pull reset low between clock edges -> alu_valid, full, to_ALU and overflow_err read 0 before the next rising edge.
